// File: rtl/mux4_arbiter_if.sv
// Request/grant bundle between the four requesters and the shared-mux arbiter.
// The requester side drives request_bits and observes the grant and the mux select.
interface mux4_arbiter_if;
   logic [3:0] request_bits;
   logic [3:0] grant_bits;
   logic [1:0] select_bits;
   logic       grant_valid;
   logic       preempt_bit;

   modport master (
      output request_bits,
      input  grant_bits,
      input  select_bits,
      input  grant_valid,
      input  preempt_bit
   );

   modport slave (
      input  request_bits,
      output grant_bits,
      output select_bits,
      output grant_valid,
      output preempt_bit
   );
endinterface

// File: rtl/mux4_arbiter.sv
// Round-robin arbiter with a hold limit that owns the select lines of a shared 4:1 mux.
// All outputs are registered; the winner search is combinational from the last owner.
module mux4_arbiter #(
   parameter int unsigned MAX_HOLD = 4
) (
   input logic           clk,
   input logic           rst_n,
   mux4_arbiter_if.slave bus
);

   typedef enum logic {
      ST_IDLE,
      ST_GRANTED
   } state_t;

   localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

   state_t     state_q, state_d;
   logic [1:0] last_owner_q, last_owner_d;
   logic [3:0] hold_count_q, hold_count_d;
   logic [3:0] grant_q, grant_d;
   logic [1:0] select_q, select_d;
   logic       valid_q, valid_d;
   logic       preempt_q, preempt_d;

   logic [3:0] req;
   logic [3:0] owner_mask;
   logic       owner_req;
   logic [2:0] pick_any;
   logic [2:0] pick_other;

   // Returns {found, index}; the first hit scanning last+1, last+2, last+3, last+4 (mod 4).
   function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      for (int k = 3; k >= 0; k--) begin
         idx = last + 2'(k + 1);
         if (r[idx]) begin
            res = {1'b1, idx};
         end
      end
      return res;
   endfunction

   assign req        = bus.request_bits;
   assign owner_mask = 4'b0001 << last_owner_q;
   assign owner_req  = |(req & owner_mask);
   assign pick_any   = rr_pick(req, last_owner_q);
   assign pick_other = rr_pick(req & ~owner_mask, last_owner_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         last_owner_q <= 2'd3;
         hold_count_q <= 4'd0;
         grant_q      <= 4'b0000;
         select_q     <= 2'd0;
         valid_q      <= 1'b0;
         preempt_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
         hold_count_q <= hold_count_d;
         grant_q      <= grant_d;
         select_q     <= select_d;
         valid_q      <= valid_d;
         preempt_q    <= preempt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      last_owner_d = last_owner_q;
      hold_count_d = hold_count_q;
      grant_d      = grant_q;
      select_d     = select_q;
      valid_d      = valid_q;
      preempt_d    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (pick_any[2]) begin
               state_d      = ST_GRANTED;
               last_owner_d = pick_any[1:0];
               select_d     = pick_any[1:0];
               grant_d      = 4'b0001 << pick_any[1:0];
               valid_d      = 1'b1;
               hold_count_d = 4'd1;
            end
         end

         ST_GRANTED: begin
            if (owner_req) begin
               if (hold_count_q < HOLD_LIMIT) begin
                  hold_count_d = hold_count_q + 4'd1;
               end else if (pick_other[2]) begin
                  // Hold limit reached with someone waiting: force the handover.
                  last_owner_d = pick_other[1:0];
                  select_d     = pick_other[1:0];
                  grant_d      = 4'b0001 << pick_other[1:0];
                  hold_count_d = 4'd1;
                  preempt_d    = 1'b1;
               end else begin
                  hold_count_d = 4'd1;
               end
            end else if (pick_any[2]) begin
               // Owner released; hand over on the same edge so the bus never idles.
               last_owner_d = pick_any[1:0];
               select_d     = pick_any[1:0];
               grant_d      = 4'b0001 << pick_any[1:0];
               hold_count_d = 4'd1;
            end else begin
               state_d      = ST_IDLE;
               grant_d      = 4'b0000;
               valid_d      = 1'b0;
               hold_count_d = 4'd0;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.grant_bits  = grant_q;
   assign bus.select_bits = select_q;
   assign bus.grant_valid = valid_q;
   assign bus.preempt_bit = preempt_q;

   a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));
   a_valid_match   : assert property (@(posedge clk) disable iff (!rst_n) valid_q == (|grant_q));
   a_select_match  : assert property (@(posedge clk) disable iff (!rst_n)
                                      valid_q |-> (grant_q == (4'b0001 << select_q)));

endmodule

// File: tb/tb_mux4_arbiter.sv
// Directed bench for mux4_arbiter: an owner/last/hold model checked every cycle,
// plus hand-computed expectations at the interesting points.
module tb_mux4_arbiter;

   localparam int MAX_HOLD = 4;

   logic clk = 1'b0;
   logic rst_n;

   mux4_arbiter_if bus_if ();

   mux4_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if.slave)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Model: owner index (-1 = idle), last owner, consecutive hold cycles.
   int   m_owner;
   int   m_last;
   int   m_hold;
   int   m_sel;
   logic m_pre;

   function automatic int search(input logic [3:0] r, input int last, input int excl);
      for (int k = 1; k <= 4; k++) begin
         int j = (last + k) % 4;
         if (r[j] && j != excl) return j;
      end
      return -1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_owner <= -1;
         m_last  <= 3;
         m_hold  <= 0;
         m_sel   <= 0;
         m_pre   <= 1'b0;
      end else begin
         m_pre <= 1'b0;
         if (m_owner < 0) begin
            if (search(bus_if.request_bits, m_last, -1) >= 0) begin
               m_owner <= search(bus_if.request_bits, m_last, -1);
               m_last  <= search(bus_if.request_bits, m_last, -1);
               m_sel   <= search(bus_if.request_bits, m_last, -1);
               m_hold  <= 1;
            end
         end else if (bus_if.request_bits[m_owner]) begin
            if (m_hold < MAX_HOLD) begin
               m_hold <= m_hold + 1;
            end else if (search(bus_if.request_bits, m_last, m_owner) >= 0) begin
               m_owner <= search(bus_if.request_bits, m_last, m_owner);
               m_last  <= search(bus_if.request_bits, m_last, m_owner);
               m_sel   <= search(bus_if.request_bits, m_last, m_owner);
               m_hold  <= 1;
               m_pre   <= 1'b1;
            end else begin
               m_hold <= 1;
            end
         end else if (search(bus_if.request_bits, m_last, -1) >= 0) begin
            m_owner <= search(bus_if.request_bits, m_last, -1);
            m_last  <= search(bus_if.request_bits, m_last, -1);
            m_sel   <= search(bus_if.request_bits, m_last, -1);
            m_hold  <= 1;
         end else begin
            m_owner <= -1;
            m_hold  <= 0;
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      check("cmp_grant",   bus_if.grant_bits,
            (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner));
      check("cmp_valid",   {3'b000, bus_if.grant_valid},   {3'b000, (m_owner >= 0)});
      check("cmp_select",  {2'b00, bus_if.select_bits},    {2'b00, 2'(m_sel)});
      check("cmp_preempt", {3'b000, bus_if.preempt_bit},   {3'b000, m_pre});
      $display("cycle t=%0t req=%b grant=%b sel=%0d valid=%b preempt=%b",
               $time, bus_if.request_bits, bus_if.grant_bits, bus_if.select_bits,
               bus_if.grant_valid, bus_if.preempt_bit);
   end

   // One clock: drive request at the falling edge, return 1 time unit after the rising edge.
   task automatic cyc(input logic [3:0] r);
      @(negedge clk);
      bus_if.request_bits = r;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n               = 1'b0;
      bus_if.request_bits = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
      check("reset_grant",   bus_if.grant_bits, 4'b0000);
      check("reset_select",  {2'b00, bus_if.select_bits}, 4'd0);
      check("reset_valid",   {3'b000, bus_if.grant_valid}, 4'd0);
      check("reset_preempt", {3'b000, bus_if.preempt_bit}, 4'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset priority
      cyc(4'b1111);
      check("prio_grant",  bus_if.grant_bits, 4'b0001);
      check("prio_select", {2'b00, bus_if.select_bits}, 4'd0);
      check("prio_valid",  {3'b000, bus_if.grant_valid}, 4'd1);

      // Rotation under full load: 4 cycles each, preempt pulse on each handover
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 3; c++) begin
            cyc(4'b1111);
            check("rot_hold_grant", bus_if.grant_bits, 4'(1 << r));
            check("rot_hold_pre",   {3'b000, bus_if.preempt_bit}, 4'd0);
         end
         cyc(4'b1111);
         check("rot_hand_grant", bus_if.grant_bits, 4'(1 << ((r + 1) % 4)));
         check("rot_hand_pre",   {3'b000, bus_if.preempt_bit}, 4'd1);
      end

      // Owner 0 releases, 2 takes over; then 2 releases into 1001 -> 3 without a bubble
      cyc(4'b0100);
      check("hand_to2_grant", bus_if.grant_bits, 4'b0100);
      cyc(4'b0100);
      cyc(4'b1001);
      check("nobubble_grant",  bus_if.grant_bits, 4'b1000);
      check("nobubble_select", {2'b00, bus_if.select_bits}, 4'd3);
      check("nobubble_valid",  {3'b000, bus_if.grant_valid}, 4'd1);
      check("nobubble_pre",    {3'b000, bus_if.preempt_bit}, 4'd0);

      // Release to idle keeps the select of the last owner
      cyc(4'b0000);
      check("idle_grant",  bus_if.grant_bits, 4'b0000);
      check("idle_valid",  {3'b000, bus_if.grant_valid}, 4'd0);
      check("idle_select", {2'b00, bus_if.select_bits}, 4'd3);

      // Sole requester past the hold limit: no preemption, grant never moves
      for (int c = 0; c < 10; c++) begin
         cyc(4'b0010);
         check("sole_grant", bus_if.grant_bits, 4'b0010);
         check("sole_pre",   {3'b000, bus_if.preempt_bit}, 4'd0);
      end

      // Requester 3 takes over, then async reset mid-cycle
      cyc(4'b1000);
      check("own3_grant", bus_if.grant_bits, 4'b1000);
      #3;
      rst_n = 1'b0;
      #1;
      check("areset_grant",  bus_if.grant_bits, 4'b0000);
      check("areset_select", {2'b00, bus_if.select_bits}, 4'd0);
      check("areset_valid",  {3'b000, bus_if.grant_valid}, 4'd0);
      bus_if.request_bits = 4'b1010;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_reset_grant",  bus_if.grant_bits, 4'b0010);
      check("post_reset_select", {2'b00, bus_if.select_bits}, 4'd1);

      // Hold limit with a single competitor: 1 keeps 4 cycles then 3 is forced in
      for (int c = 0; c < 3; c++) begin
         cyc(4'b1010);
         check("lim_hold_grant", bus_if.grant_bits, 4'b0010);
      end
      cyc(4'b1010);
      check("lim_pre_grant", bus_if.grant_bits, 4'b1000);
      check("lim_pre_pulse", {3'b000, bus_if.preempt_bit}, 4'd1);
      cyc(4'b1010);
      check("lim_pulse_end", {3'b000, bus_if.preempt_bit}, 4'd0);

      cyc(4'b0000);
      cyc(4'b0000);
      @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
